gray_bin_dec: RTL
=================

// Module: gray_bin_dec
// PURPOSE
//  Receive-side partner of the binary-to-Gray counter: takes a registered Gray-coded count,
//  decodes it to binary through a 2-stage pipeline, and checks each new sample against the
//  previous one for an illegal multi-bit Gray step. Sits at the consumer of a Gray count bus.
//  Reports per-sample step errors, a sticky error flag and a saturating error counter.
// PARAMETERS
//  WIDTH    8    Gray/binary word width (>=2)
//  ERR_W    8    error counter width; counter saturates at 2**ERR_W-1
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       gray_in is valid this cycle
//  gray_in    in   WIDTH   Gray-coded sample
//  err_clr    in   1       synchronous clear of err_sticky and err_cnt
//  out_valid  out  1       bin_out/step_err valid (pulse per accepted sample)
//  bin_out    out  WIDTH   decoded binary value, held between valids
//  step_err   out  1       1-cycle pulse with out_valid: this sample differs from the previous one in >1 bit
//  err_sticky out  1       set by any step_err, cleared only by err_clr or reset
//  err_cnt    out  ERR_W   count of step_err events, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, internal prev_gray=0, FSM=NOREF.
//  - Stage 1 (cycle N+1 after in_valid at N): register gray_in, valid, and diff = gray_in ^ prev_gray;
//    prev_gray <= gray_in on every in_valid.
//  - Stage 2 (cycle N+2): bin_out <= prefix-XOR decode: b[W-1]=g[W-1], b[i]=b[i+1]^g[i];
//    out_valid=1; step_err=1 iff FSM was TRACK for the sample and popcount(diff)>1.
//  - Latency in_valid -> out_valid: exactly 2 cycles; back-to-back in_valid gives one out_valid
//    per cycle, no bubbles, no back-pressure.
//  - FSM: NOREF --in_valid--> TRACK (first sample has no reference, never flags).
//    TRACK stays TRACK; only reset returns to NOREF.
//  - Legal steps: diff==0 (repeat/hold) or exactly one bit set. Direction is not checked:
//    +1 and -1 are both legal.
//  - Wrap: gray 0x80 (bin 255) -> 0x00 (bin 0) is a one-bit step: legal, no error.
//  - err_cnt += 1 per step_err, holds at all-ones. err_sticky <= 1 on step_err.
//  - err_clr with step_err in the same cycle: clear is applied first, then the event counts:
//    err_cnt=1, err_sticky=1.
//  - err_clr does not affect the pipeline, prev_gray or FSM.
//  - in_valid low: pipeline valids drain to 0; bin_out and prev_gray hold.
//  - rst_n asserted mid-stream: in-flight samples are discarded immediately (async);
//    after release the first sample is again unchecked.
// STRUCTURE
//  - Shared package gray_pkg: default WIDTH constant, functions bin2gray() and gray2bin();
//    the encoder counter and this decoder both use them.
//  - Sub-module gray_step_chk: popcount>1 detector on diff (combinational, WIDTH-parameterised).
//  - Top holds pipeline registers, NOREF/TRACK FSM and error counter/sticky logic.
// TESTING
//  1 Reset, drive gray 0x00,0x01,0x03,0x02 on consecutive cycles -> bin_out 0,1,2,3 on cycles
//    +2..+5, out_valid continuous, step_err=0.
//  2 Full sweep: encode bin 0..255 and wrap to 0 via gray_pkg::bin2gray -> bin_out matches each
//    value, 0x80->0x00 gives bin 255->0 with no error, err_cnt=0.
//  3 After gray 0x01 drive 0x07 (2-bit step) -> step_err pulse with bin_out=5, err_sticky=1,
//    err_cnt=1.
//  4 First sample after reset = 0xFF -> bin_out 0xAA, no step_err; repeat 0xFF -> no error.
//  5 Force 300 illegal steps -> err_cnt saturates at 255; err_clr concurrent with an error
//    -> err_cnt=1, err_sticky=1; err_clr alone -> both 0.
//  6 Assert rst_n between an in_valid and its out_valid -> no out_valid emerges, outputs 0;
//    next sample is unchecked.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the encoder counter and the decoder.
// The functions work on GRAY_MAX_W bits, so narrower words are zero-extended in and truncated out.
package gray_pkg;

   localparam int GRAY_W     = 8;
   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      NOREF = 1'b0,
      TRACK = 1'b1
   } trk_state_t;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero upper bits leave the lower result unchanged.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Flags a Gray step that changes more than one bit.
module gray_step_chk #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] diff,
   output logic             multi
);

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   always_comb begin
      multi = (diff & (diff - 1'b1)) != '0;
   end

endmodule

// File: rtl/gray_bin_dec.sv
// Gray-to-binary decoder with 2-cycle latency and multi-bit step error detection.
module gray_bin_dec
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clr,
   output logic             out_valid,
   output logic [WIDTH-1:0] bin_out,
   output logic             step_err,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_cnt
);

   trk_state_t       state_q, state_d;
   logic [WIDTH-1:0] prev_gray;
   logic [WIDTH-1:0] gray_p1, diff_p1;
   logic             vld_p1, trk_p1;
   logic [WIDTH-1:0] bin_p2;
   logic             vld_p2, err_p2;
   logic             multi_p1, err_ev;
   logic [ERR_W-1:0] cnt_q, cnt_base;
   logic             sticky_q, sticky_base;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   gray_step_chk #(.WIDTH(WIDTH)) u_step_chk (
      .diff  (diff_p1),
      .multi (multi_p1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= NOREF;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == NOREF && in_valid) state_d = TRACK;
   end

   // Stage 1: capture sample, its difference to the previous sample and whether it has a reference
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_gray <= '0;
         gray_p1   <= '0;
         diff_p1   <= '0;
         vld_p1    <= 1'b0;
         trk_p1    <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            gray_p1   <= gray_in;
            diff_p1   <= gray_in ^ prev_gray;
            prev_gray <= gray_in;
            trk_p1    <= (state_q == TRACK);
         end
      end
   end

   assign err_ev      = vld_p1 && trk_p1 && multi_p1;
   // Clear takes effect before a same-cycle error is counted.
   assign cnt_base    = err_clr ? '0 : cnt_q;
   assign sticky_base = err_clr ? 1'b0 : sticky_q;

   // Stage 2: decoded value, step error pulse and error bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_p2   <= '0;
         vld_p2   <= 1'b0;
         err_p2   <= 1'b0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         vld_p2   <= vld_p1;
         err_p2   <= err_ev;
         sticky_q <= sticky_base | err_ev;
         cnt_q    <= err_ev ? sat_inc(cnt_base) : cnt_base;
         if (vld_p1) bin_p2 <= WIDTH'(gray2bin(GRAY_MAX_W'(gray_p1)));
      end
   end

   assign out_valid  = vld_p2;
   assign bin_out    = bin_p2;
   assign step_err   = err_p2;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;

endmodule
